// File: rtl/dff_slice_array.sv
// Register slice with parameterised data-source select, global/local set-reset,
// scan shift and an optional transparent-low latch mode.
module dff_slice_array #(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  SRVAL     = '0,
    parameter int unsigned       DSEL      = 0,
    parameter int unsigned       SYNCMODE  = 0,
    parameter int unsigned       DISGSR    = 0,
    parameter int unsigned       LATCHMODE = 0
) (
    input  logic             clk,
    input  logic             gsrn,
    input  logic             ce,
    input  logic             sr,
    input  logic             shift_en,
    input  logic             scan_in,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] di,
    input  logic [WIDTH-1:0] fx,
    output logic [WIDTH-1:0] q,
    output logic             scan_out,
    output logic             gsr_busy
);

    if (DSEL > 2) begin : g_bad_dsel
        $error("dff_slice_array: DSEL must be 0 (f), 1 (di) or 2 (fx)");
    end
    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("dff_slice_array: WIDTH must be in the range 2 to 64");
    end

    localparam bit GSR_EN   = (DISGSR == 0);
    localparam bit SR_ASYNC = (SYNCMODE == 0);

    logic [1:0]       rel_q;
    logic [WIDTH-1:0] src;
    logic             arstN;
    logic             gsrHold;
    logic             unusedInputs;

    // Release synchroniser runs whatever DISGSR says; only its effect on q is gated.
    always_ff @(posedge clk or negedge gsrn) begin
        if (!gsrn) begin
            rel_q <= 2'b00;
        end else begin
            rel_q <= {rel_q[0], 1'b1};
        end
    end

    assign gsr_busy = ~rel_q[1];
    assign gsrHold  = GSR_EN && !rel_q[1];

    // Only the selected source reaches q, so X on the others cannot leak through.
    always_comb begin
        src = f;
        case (DSEL)
            1:       src = di;
            2:       src = fx;
            default: src = f;
        endcase
    end

    assign arstN        = ~((GSR_EN && !gsrn) || (SR_ASYNC && sr));
    assign unusedInputs = ^{f, di, fx, shift_en, scan_in};

    if (LATCHMODE == 0) begin : g_flop
        logic [WIDTH-1:0] q_d;
        logic [WIDTH-1:0] q_q;

        always_comb begin
            q_d = q_q;
            if (gsrHold || sr) begin
                q_d = SRVAL;
            end else if (shift_en) begin
                q_d = {q_q[WIDTH-2:0], scan_in};
            end else if (ce) begin
                q_d = src;
            end
        end

        always_ff @(posedge clk or negedge arstN) begin
            if (!arstN) begin
                q_q <= SRVAL;
            end else begin
                q_q <= q_d;
            end
        end

        assign q = q_q;
    end else begin : g_latch
        logic             latchEn;
        logic [WIDTH-1:0] q_d;
        logic [WIDTH-1:0] q_q;

        // Enable and value never depend on q itself, so the latch has no loop through it.
        always_comb begin
            latchEn = 1'b0;
            q_d     = src;
            if (gsrHold || sr) begin
                latchEn = 1'b1;
                q_d     = SRVAL;
            end else if (ce) begin
                latchEn = 1'b1;
                q_d     = src;
            end
        end

        always_latch begin
            if (!arstN) begin
                q_q = SRVAL;
            end else if (!clk && latchEn) begin
                q_q = q_d;
            end
        end

        assign q = q_q;
    end

    assign scan_out = q[WIDTH-1];

endmodule

// File: doc/dff_slice_array.md
DFF_SLICE_ARRAY -- requirements
Module: dff_slice_array

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of register bits (legal range 2 to 64).
REQ-002 SHALL have parameter SRVAL, default all-zero, WIDTH-bit value that each bit takes on reset, GSR or sr.
REQ-003 SHALL have parameter DSEL, default 0, data source select: 0 = f, 1 = di, 2 = fx; value 3 SHALL cause an elaboration error.
REQ-004 SHALL have parameter SYNCMODE, default 0: 0 = sr is asynchronous, 1 = sr is synchronous.
REQ-005 SHALL have parameter DISGSR, default 0: 1 = gsrn does not affect q. The release synchroniser still runs.
REQ-006 SHALL have parameter LATCHMODE, default 0: 0 = posedge flops, 1 = latches transparent while clk is low.
REQ-007 clk  input  1  single clock; all synchronous logic on its rising edge.
REQ-008 gsrn  input  1  global set/reset, asynchronous, active-low.
REQ-009 ce  input  1  clock enable for functional load.
REQ-010 sr  input  1  local set/reset, active-high; forces SRVAL.
REQ-011 shift_en  input  1  scan shift enable.
REQ-012 scan_in  input  1  serial scan data in.
REQ-013 f, di, fx  input  WIDTH each  candidate data sources.
REQ-014 q  output  WIDTH  register outputs.
REQ-015 scan_out  output  1  equal to q[WIDTH-1] at all times.
REQ-016 gsr_busy  output  1  high while the GSR release synchroniser has not completed.

Function
REQ-017 SHALL contain a 2-flop release synchroniser, rel[1:0]. Both bits clear asynchronously when gsrn=0. rel shifts in 1 on each clk edge otherwise. gsr_busy = ~rel[1].
REQ-018 With DISGSR=0: gsrn=0 SHALL force q=SRVAL immediately, and q SHALL stay at SRVAL until the first clk edge on which gsr_busy was already 0.
REQ-019 Release timing: after gsrn rises, edge 1 sets rel[0] and edge 2 sets rel[1]. The first load, shift or sr-load takes effect on edge 3.
REQ-020 With SYNCMODE=0: sr=1 SHALL force q=SRVAL asynchronously for as long as sr is high. Normal operation resumes on the first clk edge after sr falls.
REQ-021 With SYNCMODE=1: sr=1 on a clk edge SHALL load q=SRVAL on that edge.
REQ-022 Edge priority: gsr hold > sr > shift_en > ce > hold.
REQ-023 Shift: shift_en=1 SHALL load q <= {q[WIDTH-2:0], scan_in} regardless of ce. scan_out therefore presents the old q[WIDTH-1].
REQ-024 Load: ce=1 and shift_en=0 SHALL load q <= the source selected by DSEL, all bits in parallel.
REQ-025 Hold: ce=0 and shift_en=0 SHALL leave q unchanged.
REQ-026 With LATCHMODE=1: q SHALL follow the same priority while clk=0 and hold while clk=1. shift_en SHALL be ignored. gsr and sr forcing remain as specified.
REQ-027 Latency: posedge mode has one clk edge from input to q. Latch mode is transparent, with zero-cycle data-to-q while clk is low.
REQ-028 No X SHALL propagate from an unselected data source to q.
REQ-029 Simultaneous sr and shift_en: sr wins, and scan_in is discarded.
REQ-030 Simultaneous gsrn fall and a clk edge: the reset wins, giving q=SRVAL and rel=00.

Reset
REQ-031 After reset: q=SRVAL (DISGSR=0), rel=00, gsr_busy=1, scan_out=SRVAL[WIDTH-1].
REQ-032 With DISGSR=1: gsrn SHALL leave q unchanged, and q is undefined until the first sr or load.
REQ-033 gsrn asserted mid-shift or mid-load SHALL abort the operation immediately. No partial update SHALL remain after release.

Verification
REQ-034 Release latency: WIDTH=8, SRVAL=8'hA5, DSEL=0, f=8'h3C, ce=1; release gsrn -> q=A5 on edges 1 and 2, q=3C after edge 3, gsr_busy falls after edge 2.
REQ-035 Asynchronous sr: SYNCMODE=0, q=3C; raise sr between edges -> q=A5 with no clock edge; drop sr with f=8'h11 -> q=11 after the next edge.
REQ-036 Scan shift: q=8'h80, shift_en=1, scan_in=1, ce=0, 3 edges -> scan_out=1 before edge 1; q = 01, 03, 07 after edges 1 to 3.
REQ-037 Synchronous sr priority: SYNCMODE=1, sr=1, shift_en=1, ce=1, di=8'hFF, DSEL=1 -> q=A5 after the edge; sr=0 -> q shifts; shift_en=0 -> q=FF.
REQ-038 Latch mode: LATCHMODE=1, ce=1, f toggling 00 -> 5A while clk=0 -> q follows with zero cycles; f changes while clk=1 -> q holds 5A.
REQ-039 Reset mid-shift: gsrn pulsed low during a 3-edge shift -> q=A5 immediately; shifting resumes on edge 3 after release.
